// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: processor always wins, an auxiliary requester uses idle cycles.
// Optional statistics outputs are compiled in when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_starved,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_max_wait
`endif
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                starved_q, starved_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // The processor has no stall input, so the grant is purely what it leaves idle.
  assign aux_gnt   = !reset && (state_q == IDLE) && aux_req && !cpu_en;
  assign cpu_rdata = ram_dout;

  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    if (cpu_en) begin
      ram_wen = cpu_wren;
    end else if (aux_gnt) begin
      ram_addr = aux_addr;
      ram_din  = aux_wdata;
      ram_wen  = aux_we;
    end
    if (reset) begin
      ram_wen = 1'b0;
    end
  end

  // RD captures ram_dout for the address latched by the RAM at the grant edge,
  // so processor traffic during RD cannot disturb the returned data.
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (aux_gnt && !aux_we) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rdata_d  = ram_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (aux_gnt || !aux_req) begin
      wait_d = '0;
    end else if (wait_q < WAIT_MAX) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    starved_d = starved_q || (wait_d == WAIT_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      starved_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      starved_q <= starved_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign aux_rvalid  = rvalid_q;
  assign aux_rdata   = rdata_q;
  assign aux_starved = starved_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grants_q, grants_d;
  logic [15:0] max_wait_q, max_wait_d;
  logic [15:0] wait_clip;

  // The wait counter can be wider than the statistic; clamp rather than truncate.
  generate
    if (WAIT_W > 16) begin : g_wait_clip
      assign wait_clip = (|wait_q[WAIT_W-1:16]) ? 16'hFFFF : wait_q[15:0];
    end else begin : g_wait_pad
      assign wait_clip = 16'(wait_q);
    end
  endgenerate

  always_comb begin
    grants_d   = grants_q;
    max_wait_d = max_wait_q;
    if (aux_gnt) begin
      if (grants_q != 16'hFFFF) begin
        grants_d = grants_q + 16'd1;
      end
      if (wait_clip > max_wait_q) begin
        max_wait_d = wait_clip;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grants_q   <= '0;
      max_wait_q <= '0;
    end else begin
      grants_q   <= grants_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign stat_grants   = grants_q;
  assign stat_max_wait = max_wait_q;
`endif

endmodule
